// File: rtl/decode_operand_stage.sv
// rtl/decode_operand_stage.sv - decode operand fetch, load-use stall and ID/EX pipeline register
module decode_operand_stage #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter bit ZERO_REG     = 1'b1,
    parameter int LOAD_BUBBLES = 1
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iValid,
    output logic              oReady,
    input  logic [ADDR_W-1:0] iSrc0Addr,
    input  logic [ADDR_W-1:0] iSrc1Addr,
    input  logic              iSrc0En,
    input  logic              iSrc1En,
    input  logic [ADDR_W-1:0] iDstAddr,
    input  logic              iDstEn,
    input  logic              iIsLoad,
    input  logic              iCallCmd,
    input  logic [DATA_W-1:0] iNextPC,
    input  logic [ADDR_W-1:0] iWbAddr,
    input  logic [DATA_W-1:0] iWbData,
    input  logic              iWbEn,
    input  logic              iFlush,
    input  logic              iReady,
    output logic              oValid,
    output logic [DATA_W-1:0] oSrc0,
    output logic [DATA_W-1:0] oSrc1,
    output logic [DATA_W-1:0] oMemData,
    output logic [ADDR_W-1:0] oDstAddr,
    output logic              oDstEn,
    output logic              oIsLoad,
    output logic              oCallCmd,
    output logic              oInitDone
);
    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_STALL} state_t;

    // The hazard cycle issues the first bubble, so STALL only counts the remainder.
    localparam logic [2:0]        BUB_RELOAD = (LOAD_BUBBLES > 1) ? 3'(LOAD_BUBBLES - 2) : 3'd0;
    localparam logic [ADDR_W-1:0] CLR_LAST   = '1;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_nxt;
    logic [2:0]        r_bub_cnt, w_bub_cnt_nxt;
    logic              r_init_done;
    logic [DATA_W-1:0] r_rf [2**ADDR_W];

    logic              r_valid, r_dst_en, r_is_load, r_call;
    logic [DATA_W-1:0] r_src0, r_src1, r_mem;
    logic [ADDR_W-1:0] r_dst;

    logic              w_wb_live, w_dst_match, w_hazard, w_ready, w_accept;
    logic [DATA_W-1:0] w_src0, w_src1;

    assign w_wb_live = iWbEn && !(ZERO_REG && (iWbAddr == '0));

    assign w_src0 = (!iSrc0En || (ZERO_REG && (iSrc0Addr == '0))) ? '0 :
                    (w_wb_live && (iWbAddr == iSrc0Addr))          ? iWbData : r_rf[iSrc0Addr];
    assign w_src1 = (!iSrc1En || (ZERO_REG && (iSrc1Addr == '0))) ? '0 :
                    (w_wb_live && (iWbAddr == iSrc1Addr))          ? iWbData : r_rf[iSrc1Addr];

    assign w_dst_match = (iSrc0En && (iSrc0Addr == r_dst)) || (iSrc1En && (iSrc1Addr == r_dst));
    assign w_hazard    = r_valid && r_is_load && r_dst_en && w_dst_match &&
                         !(ZERO_REG && (r_dst == '0));
    assign w_ready     = (r_state == ST_RUN) && !w_hazard && !iFlush && (!r_valid || iReady);
    assign w_accept    = iValid && w_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_bub_cnt_nxt = r_bub_cnt;
        unique case (r_state)
            ST_INIT: begin
                w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                if (r_clr_cnt == CLR_LAST) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!iFlush && w_hazard && iReady && (LOAD_BUBBLES > 1)) begin
                    w_state_nxt   = ST_STALL;
                    w_bub_cnt_nxt = BUB_RELOAD;
                end
            end
            ST_STALL: begin
                if (iFlush || (r_bub_cnt == 3'd0)) begin
                    w_state_nxt   = ST_RUN;
                    w_bub_cnt_nxt = 3'd0;
                end else begin
                    w_bub_cnt_nxt = r_bub_cnt - 3'd1;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state     <= ST_INIT;
            r_clr_cnt   <= '0;
            r_bub_cnt   <= 3'd0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_bub_cnt   <= w_bub_cnt_nxt;
            r_init_done <= r_init_done || ((r_state == ST_INIT) && (r_clr_cnt == CLR_LAST));
        end
    end

    // No reset on the array: the INIT sweep is what clears it.
    always_ff @(posedge iClk) begin
        if (iRst_n) begin
            if (r_state == ST_INIT)  r_rf[r_clr_cnt] <= '0;
            else if (w_wb_live)      r_rf[iWbAddr]   <= iWbData;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_valid   <= 1'b0;
            r_src0    <= '0;
            r_src1    <= '0;
            r_mem     <= '0;
            r_dst     <= '0;
            r_dst_en  <= 1'b0;
            r_is_load <= 1'b0;
            r_call    <= 1'b0;
        end else if (r_state == ST_INIT || iFlush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_src0    <= w_src0;
            r_src1    <= w_src1;
            r_mem     <= iCallCmd ? iNextPC : w_src1;
            r_dst     <= iDstAddr;
            r_dst_en  <= iDstEn;
            r_is_load <= iIsLoad;
            r_call    <= iCallCmd;
        end else if (iReady || !r_valid) begin
            r_valid <= 1'b0;
        end
    end

    assign oReady    = w_ready;
    assign oValid    = r_valid;
    assign oSrc0     = r_src0;
    assign oSrc1     = r_src1;
    assign oMemData  = r_mem;
    assign oDstAddr  = r_dst;
    assign oDstEn    = r_dst_en;
    assign oIsLoad   = r_is_load;
    assign oCallCmd  = r_call;
    assign oInitDone = r_init_done;
endmodule
